serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It reuses a single full_adder instance over WIDTH cycles to add two WIDTH-bit operands, least significant bit first. A carry register is fed back into the adder between cycles. Requesters load operands with a start/ready handshake and collect the result with a valid/ack handshake. It is the first sequential consumer of the full_adder cell, trading area for latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request to begin an addition; sampled only when ready=1.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
cin  input  1  carry-in; captured on the accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in ADD only.
valid  output  1  high in DONE only; sum and cout are valid while high.
ack  input  1  consumer accepts the result; sampled only when valid=1.
sum  output  WIDTH  registered result.
cout  output  1  registered final carry-out.

Behaviour:
- Reset values, applied at the clk edge with reset=1: state=IDLE, ready=1, busy=0, valid=0, sum=0, cout=0, internal shift registers/carry/counter=0. Reset has priority over all other inputs.
- FSM states: IDLE, ADD, DONE. ready, busy and valid are decoded from the state register and are mutually exclusive.
- IDLE: if start=1 at the edge, load shA<=a, shB<=b, carry<=cin, cnt<=0, and go to ADD. Otherwise stay in IDLE.
- ADD, each edge:
  - full_adder inputs are (shA[0], shB[0], carry).
  - shA and shB shift right by 1.
  - The adder's sum bit shifts into the MSB of the internal shS register, which shifts right.
  - carry<= adder carry output; cnt<=cnt+1.
- ADD exit: on the edge where cnt==WIDTH-1:
  - sum<=the final shS value, including this cycle's bit;
  - cout<=adder carry output;
  - state<=DONE.
- Latency: start accepted at edge E0; valid=1 in the cycle following edge E0+WIDTH. Exactly WIDTH ADD cycles.
- DONE: sum and cout are held stable. ack=1 at the edge returns the FSM to IDLE (valid drops, ready rises next cycle). Without ack, DONE persists indefinitely.
- sum and cout change only on entry to DONE or on reset. They keep their last value through IDLE and ADD.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- cnt width is clog2(WIDTH)+1 bits. WIDTH=1 completes after 1 ADD cycle.
- Ignored inputs:
  - start while in ADD or DONE has no effect; operands are not re-captured.
  - ack outside DONE has no effect.
  - start and ack both high in DONE: ack is honoured, start is ignored, FSM goes to IDLE. A new start needs a later cycle with ready=1.
- Operand inputs a, b and cin may change freely after the accepted start without affecting the result.
- Reset mid-ADD or mid-DONE: the operation is aborted with no partial result. The reset values above apply on the next cycle.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy for exactly 8 cycles, then valid=1 with sum=0x10, cout=0; ack -> ready=1 next cycle.
2. WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Start 0x12+0x34, pulse start again at ADD cycle 3 with a=0xAA, b=0x55 -> result still 0x46, cout=0; the second start is ignored.
4. Hold ack=0 for 5 cycles in DONE -> valid, sum and cout stable. Assert start+ack together -> IDLE; no new operation starts until start is re-asserted.
5. Assert reset at ADD cycle 3 of 0xF0+0x0F -> next cycle ready=1, busy=0, valid=0, sum=0x00, cout=0. A fresh 0x01+0x01 afterwards -> sum=0x02.
6. WIDTH=1, all 8 (a,b,cin) combinations -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1) with 1-cycle ADD latency.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell is reused over WIDTH cycles,
// LSB first, with the carry held in a register between cycles.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shs_q, shs_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] shs_shift;

    full_adder u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state, datapath and decoded status computation
    always_comb begin
        state_d   = state_q;
        sha_d     = sha_q;
        shb_d     = shb_q;
        shs_d     = shs_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        // This cycle's sum bit enters at the MSB so the first bit lands at bit 0
        shs_shift            = shs_q >> 1'b1;
        shs_shift[WIDTH-1]   = fa_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                sha_d   = sha_q >> 1'b1;
                shb_d   = shb_q >> 1'b1;
                shs_d   = shs_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = shs_shift;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_ADD);
        valid_d = (state_d == ST_DONE);
    end

    // State, datapath and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shs_q   <= shs_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle-level arithmetic model for WIDTH=8 plus
// directed literal checks, and a WIDTH=1 truth-table sweep.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       ack = 1'b0;
    logic       ready, busy, valid, cout;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       ack1 = 1'b0;
    logic       ready1, busy1, valid1, cout1;
    logic [0:0] sum1;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .valid(valid), .ack(ack), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .valid(valid1), .ack(ack1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model for WIDTH=8: phase 0 idle, 1 adding, 2 result held
    int       m_phase = 0;
    int       m_left  = 0;
    logic [8:0] m_res = 9'h000;
    logic [7:0] m_sum = 8'h00;
    logic     m_cout  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_left <= 0; m_sum <= 8'h00; m_cout <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_left  <= 8;
                m_res   <= {1'b0, a} + {1'b0, b} + {8'h00, cin};
            end
        end else if (m_phase == 1) begin
            if (m_left == 1) begin
                m_phase <= 2;
                m_sum   <= m_res[7:0];
                m_cout  <= m_res[8];
            end else begin
                m_left <= m_left - 1;
            end
        end else begin
            if (ack) m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            chk("model8", {20'h0, ready, busy, valid, cout, sum},
                {20'h0, m_phase == 0, m_phase == 1, m_phase == 2, m_cout, m_sum});
    end

    task automatic wait_valid8(input string name, output int nbusy);
        int k;
        nbusy = 0;
        for (k = 0; k < 40 && !valid; k++) begin
            if (busy) nbusy++;
            @(negedge clk);
        end
        if (!valid) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic [8:0] exp);
        int nb;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        @(negedge clk);
        start = 1'b0;
        wait_valid8(name, nb);
        chk({name, "_busy_cycles"}, nb, 32'd8);
        chk({name, "_result"}, {23'h0, cout, sum}, {23'h0, exp});
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({name, "_ready_after_ack"}, {31'h0, ready}, 32'd1);
    endtask

    initial begin
        int nb;
        logic [8:0] held;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("reset_state", {20'h0, ready, busy, valid, cout, sum}, {20'h0, 4'b1000, 8'h00});

        // Plan 1 and 2
        run8("p1_0f_01", 8'h0F, 8'h01, 1'b0, 9'h010);
        run8("p2_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
        run8("p2_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Plan 3: second start during ADD is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid8("p3", nb);
        chk("p3_result", {23'h0, cout, sum}, {23'h0, 9'h046});

        // Plan 4: DONE holds without ack, then start+ack together
        held = {cout, sum};
        repeat (5) @(negedge clk);
        chk("p4_hold", {22'h0, valid, cout, sum}, {22'h0, 1'b1, held});
        start = 1'b1; ack = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("p4_idle", {29'h0, ready, busy, valid}, {29'h0, 3'b100});
        repeat (3) @(negedge clk);
        chk("p4_no_restart", {29'h0, ready, busy, valid}, {29'h0, 3'b100});

        // Plan 5: reset mid-ADD aborts
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("p5_busy_before_reset", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("p5_after_reset", {20'h0, ready, busy, valid, cout, sum}, {20'h0, 4'b1000, 8'h00});
        run8("p5_01_01", 8'h01, 8'h01, 1'b0, 9'h002);

        // Plan 6: WIDTH=1 truth table, one ADD cycle
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            @(negedge clk);
            start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1_busy_%0d", i), {30'h0, busy1, valid1}, {30'h0, 2'b10});
            @(negedge clk);
            chk($sformatf("w1_res_%0d", i), {29'h0, valid1, cout1, sum1},
                {29'h0, 1'b1, 2'({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]})});
            ack1 = 1'b1;
            @(negedge clk);
            ack1 = 1'b0;
        end
        chk("w1_111_literal", {30'h0, cout1, sum1}, {30'h0, 2'b11});

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
